// File: rtl/qif_neuron_scheduler.sv
// Quadratic integrate-and-fire scheduler: one shared 8-bit update datapath swept over NUM_NEURONS state slots.
// Sweep latency 1 + NUM_NEURONS + 1 cycles unstalled; a pending unaccepted spike stalls the sweep in place.
module qif_neuron_scheduler #(
    parameter int                NUM_NEURONS = 4,
    parameter logic signed [7:0] V_TH        = 8'sd50,
    parameter logic signed [7:0] V_RESET     = -8'sd20,
    localparam int               IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             step_done,
    input  logic             syn_we,
    input  logic [IDX_W-1:0] syn_addr,
    input  logic [7:0]       syn_data,
    output logic             spike_valid,
    input  logic             spike_ready,
    output logic [IDX_W-1:0] spike_id,
    input  logic [IDX_W-1:0] v_rd_addr,
    output logic [7:0]       v_rd_data
);

    typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic signed [7:0] v_q [NUM_NEURONS];
    logic signed [7:0] v_d [NUM_NEURONS];
    logic signed [7:0] i_q [NUM_NEURONS];
    logic signed [7:0] i_d [NUM_NEURONS];
    logic              busy_q, busy_d;
    logic              step_done_q, step_done_d;
    logic              spike_valid_q, spike_valid_d;
    logic [IDX_W-1:0]  spike_id_q, spike_id_d;

    logic              slot_free, commit, fire, syn_addr_ok, rd_addr_ok;
    logic signed [7:0]  v_cur, i_cur;
    logic signed [15:0] v_ext, i_ext, v_div8, i_div4, upd_sum;

    assign syn_addr_ok = int'(syn_addr) < NUM_NEURONS;
    assign rd_addr_ok  = int'(v_rd_addr) < NUM_NEURONS;

    always_comb begin
        v_cur   = v_q[idx_q];
        i_cur   = i_q[idx_q];
        v_ext   = {{8{v_cur[7]}}, v_cur};
        i_ext   = {{8{i_cur[7]}}, i_cur};
        // Signed division truncates toward zero, which is the intended rounding.
        v_div8  = v_ext / 16'sd8;
        i_div4  = i_ext / 16'sd4;
        upd_sum = v_ext + i_div4 + v_div8 * v_div8;
        fire    = v_cur >= V_TH;

        slot_free = !spike_valid_q || spike_ready;
        commit    = (state_q == SWEEP) && slot_free;

        state_d       = state_q;
        idx_d         = idx_q;
        v_d           = v_q;
        i_d           = i_q;
        spike_valid_d = spike_valid_q;
        spike_id_d    = spike_id_q;

        if (spike_valid_q && spike_ready) begin
            spike_valid_d = 1'b0;
        end

        // A new spike loading on the accept cycle overrides the clear, giving back-to-back events.
        if (commit) begin
            if (fire) begin
                v_d[idx_q]    = V_RESET;
                spike_valid_d = 1'b1;
                spike_id_d    = idx_q;
            end else begin
                v_d[idx_q] = upd_sum[7:0];
            end
        end

        if (syn_we && syn_addr_ok) begin
            i_d[syn_addr] = syn_data;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (commit) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d      = state_d != IDLE;
        step_done_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            step_done_q   <= 1'b0;
            spike_valid_q <= 1'b0;
            spike_id_q    <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                v_q[n] <= '0;
                i_q[n] <= '0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            busy_q        <= busy_d;
            step_done_q   <= step_done_d;
            spike_valid_q <= spike_valid_d;
            spike_id_q    <= spike_id_d;
            v_q           <= v_d;
            i_q           <= i_d;
        end
    end

    assign busy        = busy_q;
    assign step_done   = step_done_q;
    assign spike_valid = spike_valid_q;
    assign spike_id    = spike_id_q;
    assign v_rd_data   = rd_addr_ok ? v_q[v_rd_addr] : 8'h00;

endmodule
